// File: rtl/ysyx_23060240_mem_resp.sv
// Fixed-latency memory responder for the NPC data port: one outstanding request,
// byte-masked 32-bit writes, aligned 32-bit reads, error response outside the window.
module ysyx_23060240_mem_resp #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     mem [DEPTH];
  logic [3:0]      cnt;
  logic            wen_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     rdata_q;

  logic [31:0]     off;
  logic            err;
  logic [AW-1:0]   idx;
  logic            accept;
  logic            capture;
  logic            cap_blank;
  logic [AW-1:0]   cap_idx;
  logic            unused_mask;

  assign off         = req_addr - BASE;
  assign err         = off >= 32'(4 * DEPTH);
  assign idx         = off[AW+1:2];
  assign accept      = req_valid && req_ready;
  assign unused_mask = ^req_wmask[7:4];

  // With LATENCY==1 the read word is captured on the acceptance edge itself,
  // so the capture source bypasses the latched request fields.
  always_comb begin
    capture   = 1'b0;
    cap_blank = wen_q || err_q;
    cap_idx   = idx_q;
    if (state == IDLE) begin
      capture   = accept && (LATENCY == 1);
      cap_blank = req_wen || err;
      cap_idx   = idx;
    end else if (state == WAIT) begin
      capture   = (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    if (state == IDLE) req_ready = !rst;
    if (state == RESP) begin
      resp_valid = 1'b1;
      resp_rdata = rdata_q;
      resp_err   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt   <= 4'(LATENCY - 1);
        wen_q <= req_wen;
        err_q <= err;
        idx_q <= idx;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) rdata_q <= cap_blank ? '0 : mem[cap_idx];
    end
  end

  // Writes commit at acceptance; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && req_wen && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_wmask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/ysyx_23060240_mem_resp.md
# ysyx_23060240_mem_resp

Memory responder for the NPC data port: the slave end of the load/store path that accepts one request at a time over a valid/ready handshake, performs a byte-masked 32-bit write or an aligned 32-bit read against an internal word array, and returns a response after a fixed, parameterised latency. It sits between the MEM stage and physical memory, replacing the zero-latency DPI access with a cycle-accurate timing model. Load-side byte/half extraction and sign extension stay in the initiator. This block always returns the full aligned word.

## Interface
Parameters:
- BASE, 32'h8000_0000, byte address mapped to word 0
- DEPTH, 1024, number of 32-bit words (power of two)
- LATENCY, 2, cycles from request acceptance to resp_valid (legal 1..15)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder idle and able to accept
- req_wen  input  1  1 = write, 0 = read
- req_addr  input  32  byte address; bits [1:0] ignored
- req_wdata  input  32  write data, byte lanes already positioned by initiator
- req_wmask  input  8  byte enables; bit i enables byte lane i for i=0..3; bits [7:4] ignored
- resp_valid  output  1  response present
- resp_ready  input  1  initiator accepts response
- resp_rdata  output  32  aligned read word (0 for writes and errors)
- resp_err  output  1  address outside [BASE, BASE+4*DEPTH)

## Operation
- State machine: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch wen, word index, error flag and mask. Load counter with LATENCY-1. Go to WAIT, or go straight to RESP if LATENCY==1.
- Write commit: at the acceptance edge, only if in range. Byte lane i is updated iff req_wmask[i]. A wmask of 0 is a legal no-op write.
- WAIT: counter decrements each cycle. When it reaches 0, capture the read word (array[idx], or 0 if wen or err) into resp_rdata, set resp_valid, and go to RESP.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_valid&&resp_ready. Then return to IDLE. No new request is accepted in that same cycle, so there is one bubble.
- Range check: off = req_addr - BASE (32-bit wrap). err = (off >= 4*DEPTH). Index = off[log2(DEPTH)+1:2].
- Errored accesses never modify the array and return resp_rdata=0, resp_err=1.
- At most one outstanding request. req_ready=0 in WAIT and RESP.
- Memory contents are not initialised by reset.

## Timing
- Reset values: req_ready=0 while rst is high, then 1 from the first cycle after rst deasserts. resp_valid=0, resp_rdata=0, resp_err=0. State is IDLE and the counter is 0.
- Acceptance at edge t gives resp_valid=1 in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after the accept cycle.
- Read-after-write: a read accepted after a write's response has completed observes the written bytes.
- Backpressure: resp_ready=0 holds RESP indefinitely with all outputs frozen.
- Request inputs are sampled only at the acceptance edge. Changes while req_ready=0 are ignored.
- Reset mid-operation (WAIT or RESP) abandons the transaction. The next cycle is IDLE with resp_valid=0. A write that was already accepted stays committed.
- req_valid asserted with rst high is not accepted.

## Test plan
- Reset: hold rst 3 cycles with req_valid=1 -> req_ready=0 and resp_valid=0 throughout. req_ready=1 on the first post-reset cycle.
- Write then read, LATENCY=2: write 0x8000_0010, data 0xDEAD_BEEF, mask 0x0F -> resp_valid 2 cycles after accept with resp_err=0. Then read 0x8000_0013 -> resp_rdata=0xDEAD_BEEF.
- Byte mask: after the previous step, write 0x8000_0010, data 0x1122_3344, mask 0x05 -> read returns 0xDE22_BE44. Mask 0xF0 -> word unchanged.
- Backpressure: read with resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stable. req_valid is held high but no second accept until 1 cycle after the resp handshake.
- Out of range: read 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024) -> resp_err=1, resp_rdata=0. Write to 0x8000_1000 -> word 0 is not modified.
- Reset mid-WAIT: LATENCY=4, accept a read, assert rst in cycle 2 -> resp_valid never rises for it. A fresh read after reset completes normally in 4 cycles.
